// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the fetch-PC redirect logic.
//   state_e : redirect controller states (run / holding a redirect / flushing)
//   src_e   : redirect source class; numeric order is the arbitration priority
//   INSTR_BYTES : fetch stride in bytes
package pc_redirect_unit_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   // Higher encoding wins: branch (EX, older) > jr > jump (both ID).
   typedef enum logic [1:0] {
      SRC_NONE   = 2'd0,
      SRC_JUMP   = 2'd1,
      SRC_JR     = 2'd2,
      SRC_BRANCH = 2'd3
   } src_e;

   localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational redirect target formation and priority select.
//   jump_*   : J/JAL index and PC+4 of the jump (upper nibble used)
//   jr_*     : JR register value (forced word aligned)
//   branch_* : taken-branch target from EX
//   target / src / valid : winning redirect
//   jr_misaligned : winning JR target had nonzero low bits
module pc_target_mux
   import pc_redirect_unit_pkg::*;
(
   input  logic        jump_valid,
   input  logic [25:0] jump_index,
   input  logic [31:0] jump_pc,
   input  logic        jr_valid,
   input  logic [31:0] jr_target,
   input  logic        branch_valid,
   input  logic [31:0] branch_target,
   output logic [31:0] target,
   output src_e        src,
   output logic        valid,
   output logic        jr_misaligned
);

   // Only the region nibble of the jump's PC+4 participates.
   logic unused_jump_pc_low;
   assign unused_jump_pc_low = ^jump_pc[27:0];

   always_comb begin
      target = '0;
      src    = SRC_NONE;
      if (branch_valid) begin
         target = branch_target;
         src    = SRC_BRANCH;
      end else if (jr_valid) begin
         target = {jr_target[31:2], 2'b00};
         src    = SRC_JR;
      end else if (jump_valid) begin
         target = {jump_pc[31:28], jump_index, 2'b00};
         src    = SRC_JUMP;
      end
   end

   assign valid         = (src != SRC_NONE);
   assign jr_misaligned = jr_valid && !branch_valid && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: arbitrates jump / jr / branch redirects, buffers one
// redirect across stalls and flags wrong-path IF/ID contents.
//   Clk, Rst (async active-low), Stall
//   JumpValid/JumpIndex/JumpPC, JrValid/JrTarget, BranchValid/BranchTarget
//   PC, PCPlus4 (comb), Flush, PendingRedirect, Misaligned (sticky)
module pc_redirect_unit
   import pc_redirect_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 1
)(
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        JumpValid,
   input  logic [25:0] JumpIndex,
   input  logic [31:0] JumpPC,
   input  logic        JrValid,
   input  logic [31:0] JrTarget,
   input  logic        BranchValid,
   input  logic [31:0] BranchTarget,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        Flush,
   output logic        PendingRedirect,
   output logic        Misaligned
);

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_target_q, buf_target_d;
   src_e        buf_src_q, buf_src_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        flush_q, flush_d;
   logic        misaligned_q, misaligned_d;

   logic [31:0] redir_target;
   src_e        redir_src;
   logic        redir_valid;
   logic        redir_jr_mis;

   pc_target_mux u_mux (
      .jump_valid    (JumpValid),
      .jump_index    (JumpIndex),
      .jump_pc       (JumpPC),
      .jr_valid      (JrValid),
      .jr_target     (JrTarget),
      .branch_valid  (BranchValid),
      .branch_target (BranchTarget),
      .target        (redir_target),
      .src           (redir_src),
      .valid         (redir_valid),
      .jr_misaligned (redir_jr_mis)
   );

   assign PCPlus4 = pc_q + 32'(INSTR_BYTES);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      buf_target_d = buf_target_q;
      buf_src_d    = buf_src_q;
      cnt_d        = cnt_q;
      misaligned_d = misaligned_q | redir_jr_mis;

      if (Stall) begin
         // Buffer a redirect unless it loses to the one already held.
         // The flush count is frozen, so Flush stays up across the stall.
         if (redir_valid && (state_q != ST_HOLD || redir_src >= buf_src_q)) begin
            buf_target_d = redir_target;
            buf_src_d    = redir_src;
            state_d      = ST_HOLD;
         end
      end else if (state_q == ST_HOLD) begin
         // Only an EX branch is older than the buffered redirect.
         pc_d         = (redir_src == SRC_BRANCH) ? redir_target : buf_target_q;
         buf_target_d = '0;
         buf_src_d    = SRC_NONE;
         cnt_d        = FLUSH_LOAD;
         state_d      = ST_FLUSH;
      end else if (redir_valid) begin
         pc_d    = redir_target;
         cnt_d   = FLUSH_LOAD;
         state_d = ST_FLUSH;
      end else begin
         pc_d = PCPlus4;
         if (state_q == ST_FLUSH) begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
               state_d = ST_RUN;
            end
         end
      end

      flush_d = (cnt_d != '0);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_PC;
         buf_target_q <= '0;
         buf_src_q    <= SRC_NONE;
         cnt_q        <= '0;
         flush_q      <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         buf_target_q <= buf_target_d;
         buf_src_q    <= buf_src_d;
         cnt_q        <= cnt_d;
         flush_q      <= flush_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign PC              = pc_q;
   assign Flush           = flush_q;
   assign PendingRedirect = (state_q == ST_HOLD);
   assign Misaligned      = misaligned_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam int          FC     = 2;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Stall;
   logic        JumpValid;
   logic [25:0] JumpIndex;
   logic [31:0] JumpPC;
   logic        JrValid;
   logic [31:0] JrTarget;
   logic        BranchValid;
   logic [31:0] BranchTarget;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        Flush;
   logic        PendingRedirect;
   logic        Misaligned;

   int errors = 0;
   int checks = 0;

   pc_redirect_unit #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FC)) dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .Stall           (Stall),
      .JumpValid       (JumpValid),
      .JumpIndex       (JumpIndex),
      .JumpPC          (JumpPC),
      .JrValid         (JrValid),
      .JrTarget        (JrTarget),
      .BranchValid     (BranchValid),
      .BranchTarget    (BranchTarget),
      .PC              (PC),
      .PCPlus4         (PCPlus4),
      .Flush           (Flush),
      .PendingRedirect (PendingRedirect),
      .Misaligned      (Misaligned)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        stall;
      logic        jv;
      logic [25:0] jidx;
      logic [31:0] jpc;
      logic        jrv;
      logic [31:0] jrt;
      logic        bv;
      logic [31:0] bt;
      logic [31:0] e_pc;
      logic        e_flush;
      logic        e_pend;
      logic        e_mis;
   } vec_t;

   vec_t vecs[21];

   function automatic vec_t mk(logic st, logic jv, logic [25:0] ji, logic [31:0] jp,
                               logic jrv, logic [31:0] jrt, logic bv, logic [31:0] bt,
                               logic [31:0] epc, logic ef, logic ep, logic em);
      vec_t v;
      v.stall = st; v.jv = jv; v.jidx = ji; v.jpc = jp;
      v.jrv = jrv; v.jrt = jrt; v.bv = bv; v.bt = bt;
      v.e_pc = epc; v.e_flush = ef; v.e_pend = ep; v.e_mis = em;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic jv, input logic [25:0] ji, input logic [31:0] jp,
                        input logic jrv, input logic [31:0] jrt, input logic bv, input logic [31:0] bt);
      Stall = st; JumpValid = jv; JumpIndex = ji; JumpPC = jp;
      JrValid = jrv; JrTarget = jrt; BranchValid = bv; BranchTarget = bt;
   endtask

   // Reference model: PC, one pending slot with a numeric priority, a count
   // of remaining flush cycles and the sticky misalignment flag.
   logic [31:0] m_pc;
   bit          m_pend;
   logic [31:0] m_ptgt;
   int          m_pprio;
   int          m_fl;
   bit          m_mis;

   task automatic model_reset();
      m_pc = RST_PC; m_pend = 0; m_ptgt = '0; m_pprio = 0; m_fl = 0; m_mis = 0;
   endtask

   task automatic model_step();
      int          prio;
      logic [31:0] tgt;
      prio = 0;
      tgt  = '0;
      if (BranchValid) begin
         prio = 3; tgt = BranchTarget;
      end else if (JrValid) begin
         prio = 2; tgt = JrTarget & 32'hFFFF_FFFC;
         if (JrTarget[1:0] != 2'b00) m_mis = 1;
      end else if (JumpValid) begin
         prio = 1; tgt = (JumpPC & 32'hF000_0000) | ({6'd0, JumpIndex} * 4);
      end
      if (Stall) begin
         if (prio > 0 && (!m_pend || prio >= m_pprio)) begin
            m_pend = 1; m_ptgt = tgt; m_pprio = prio;
         end
      end else if (m_pend) begin
         m_pc   = (prio == 3) ? tgt : m_ptgt;
         m_pend = 0; m_pprio = 0;
         m_fl   = FC;
      end else if (prio > 0) begin
         m_pc = tgt;
         m_fl = FC;
      end else begin
         m_pc = m_pc + 4;
         if (m_fl > 0) m_fl--;
      end
   endtask

   initial begin
      logic [31:0] r;
      drive(0, 0, '0, '0, 0, '0, 0, '0);
      Rst = 1'b0;

      //            st jv jidx       jpc            jrv jrt            bv bt             e_pc           F  P  M
      vecs[0]  = mk(0, 0, '0,        '0,            0, '0,            0, '0,            32'h0040_0004, 0, 0, 0);
      vecs[1]  = mk(0, 0, '0,        '0,            0, '0,            0, '0,            32'h0040_0008, 0, 0, 0);
      vecs[2]  = mk(0, 1, 26'h100,   32'h9000_0010, 0, '0,            0, '0,            32'h9000_0400, 1, 0, 0);
      vecs[3]  = mk(0, 0, '0,        '0,            0, '0,            0, '0,            32'h9000_0404, 1, 0, 0);
      vecs[4]  = mk(0, 0, '0,        '0,            0, '0,            0, '0,            32'h9000_0408, 0, 0, 0);
      vecs[5]  = mk(0, 1, 26'h5,     32'h9000_0010, 0, '0,            1, 32'h0000_0200, 32'h0000_0200, 1, 0, 0);
      vecs[6]  = mk(0, 0, '0,        '0,            0, '0,            0, '0,            32'h0000_0204, 1, 0, 0);
      vecs[7]  = mk(0, 0, '0,        '0,            0, '0,            0, '0,            32'h0000_0208, 0, 0, 0);
      vecs[8]  = mk(1, 1, 26'h100,   32'h9000_0010, 0, '0,            0, '0,            32'h0000_0208, 0, 1, 0);
      vecs[9]  = mk(1, 0, '0,        '0,            0, '0,            1, 32'h0000_0800, 32'h0000_0208, 0, 1, 0);
      vecs[10] = mk(1, 0, '0,        '0,            0, '0,            0, '0,            32'h0000_0208, 0, 1, 0);
      vecs[11] = mk(0, 0, '0,        '0,            0, '0,            0, '0,            32'h0000_0800, 1, 0, 0);
      vecs[12] = mk(0, 0, '0,        '0,            0, '0,            0, '0,            32'h0000_0804, 1, 0, 0);
      vecs[13] = mk(0, 0, '0,        '0,            0, '0,            0, '0,            32'h0000_0808, 0, 0, 0);
      vecs[14] = mk(0, 0, '0,        '0,            1, 32'h0000_1006, 0, '0,            32'h0000_1004, 1, 0, 1);
      vecs[15] = mk(0, 0, '0,        '0,            0, '0,            0, '0,            32'h0000_1008, 1, 0, 1);
      vecs[16] = mk(0, 1, 26'h40,    32'h0000_0004, 0, '0,            0, '0,            32'h0000_0100, 1, 0, 1);
      vecs[17] = mk(0, 0, '0,        '0,            0, '0,            0, '0,            32'h0000_0104, 1, 0, 1);
      vecs[18] = mk(0, 0, '0,        '0,            0, '0,            0, '0,            32'h0000_0108, 0, 0, 1);
      vecs[19] = mk(0, 0, '0,        '0,            1, 32'hFFFF_FFFC, 0, '0,            32'hFFFF_FFFC, 1, 0, 1);
      vecs[20] = mk(0, 0, '0,        '0,            0, '0,            0, '0,            32'h0000_0000, 1, 0, 1);

      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("reset_pc", PC, RST_PC);
      chk("reset_flush", 32'(Flush), 0);
      chk("reset_pend", 32'(PendingRedirect), 0);
      chk("reset_mis", 32'(Misaligned), 0);
      Rst = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].stall, vecs[i].jv, vecs[i].jidx, vecs[i].jpc,
               vecs[i].jrv, vecs[i].jrt, vecs[i].bv, vecs[i].bt);
         @(posedge Clk); #1;
         chk($sformatf("vec%0d_pc", i), PC, vecs[i].e_pc);
         chk($sformatf("vec%0d_pcplus4", i), PCPlus4, vecs[i].e_pc + 32'd4);
         chk($sformatf("vec%0d_flush", i), 32'(Flush), 32'(vecs[i].e_flush));
         chk($sformatf("vec%0d_pend", i), 32'(PendingRedirect), 32'(vecs[i].e_pend));
         chk($sformatf("vec%0d_mis", i), 32'(Misaligned), 32'(vecs[i].e_mis));
         @(negedge Clk);
      end

      // Reset while holding a buffered redirect.
      drive(1, 1, 26'h3FF, 32'h5000_0000, 0, '0, 0, '0);
      @(posedge Clk); #1;
      chk("hold_pend", 32'(PendingRedirect), 1);
      chk("hold_pc_frozen", PC, 32'h0000_0000);
      @(negedge Clk);
      drive(0, 0, '0, '0, 0, '0, 0, '0);
      Rst = 1'b0;
      #1;
      chk("rst_hold_pc", PC, RST_PC);
      chk("rst_hold_pend", 32'(PendingRedirect), 0);
      chk("rst_hold_flush", 32'(Flush), 0);
      chk("rst_hold_mis", 32'(Misaligned), 0);
      @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk); #1;
      chk("rst_hold_release_pc", PC, RST_PC + 32'd4);
      chk("rst_hold_release_flush", 32'(Flush), 0);
      @(negedge Clk);

      // Randomized run against the reference model.
      model_reset();
      m_pc = RST_PC + 32'd4;
      for (int n = 0; n < 600; n++) begin
         Stall       = ($urandom_range(0, 9) < 3);
         JumpValid   = ($urandom_range(0, 3) == 0);
         JumpIndex   = 26'($urandom);
         JumpPC      = $urandom;
         JrValid     = ($urandom_range(0, 5) == 0);
         r           = $urandom;
         if ($urandom_range(0, 29) != 0) r[1:0] = 2'b00;
         JrTarget    = r;
         BranchValid = ($urandom_range(0, 6) == 0);
         BranchTarget = $urandom & 32'hFFFF_FFFC;
         model_step();
         @(posedge Clk); #1;
         chk($sformatf("rnd%0d_pc", n), PC, m_pc);
         chk($sformatf("rnd%0d_pcplus4", n), PCPlus4, m_pc + 32'd4);
         chk($sformatf("rnd%0d_flush", n), 32'(Flush), 32'(m_fl > 0));
         chk($sformatf("rnd%0d_pend", n), 32'(PendingRedirect), 32'(m_pend));
         chk($sformatf("rnd%0d_mis", n), 32'(Misaligned), 32'(m_mis));
         @(negedge Clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
